// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle between the execution-rate controller and its host.
interface clk_step_ctrl_if;
    logic        run_sw;
    logic        rate_sel;
    logic        step_btn;
    logic        halt_req;
    logic        clr;
    logic        cpu_en;
    logic        out_clk;
    logic [1:0]  state;
    logic [31:0] inst_cnt;
    logic        trap;

    modport master (
        output run_sw, rate_sel, step_btn, halt_req, clr,
        input  cpu_en, out_clk, state, inst_cnt, trap
    );

    modport slave (
        input  run_sw, rate_sel, step_btn, halt_req, clr,
        output cpu_en, out_clk, state, inst_cnt, trap
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// Execution-rate controller: issues one-cycle cpu_en strobes from free-running
// dividers or a debounced step button, and blocks them while trapped.
module clk_step_ctrl #(
    parameter int unsigned DIV_SLOW   = 50000000,
    parameter int unsigned DIV_FAST   = 50000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input logic            clk,
    input logic            rst,
    clk_step_ctrl_if.slave bus
);
    localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int unsigned DW      = $clog2(DIV_MAX);
    localparam int unsigned BW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] SLOW_LAST = DW'(DIV_SLOW - 1);
    localparam logic [DW-1:0] FAST_LAST = DW'(DIV_FAST - 1);
    localparam logic [BW-1:0] DEB_LAST  = BW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STEP = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t        cur, nxt;
    logic          sync1, s2, db, db_prev;
    logic [BW-1:0] deb_cnt;
    logic          rate_q;
    logic [DW-1:0] div_cnt, div_nxt, div_last;
    logic          step_evt, rate_chg, strobe;
    logic          cpu_en_r, out_clk_r, trap_r;
    logic [31:0]   inst_cnt_r;

    // Button path runs in every state; only STEP consumes its events.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            s2      <= 1'b0;
            db      <= 1'b0;
            db_prev <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1   <= bus.step_btn;
            s2      <= sync1;
            db_prev <= db;
            if (s2 == db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                db      <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + BW'(1);
            end
        end
    end

    // Previous rate_sel is tracked even through reset so that leaving reset
    // never looks like a rate change.
    always_ff @(posedge clk) begin
        rate_q <= bus.rate_sel;
    end

    assign step_evt = db & ~db_prev;
    assign rate_chg = bus.rate_sel != rate_q;
    assign div_last = bus.rate_sel ? FAST_LAST : SLOW_LAST;

    always_ff @(posedge clk) begin
        if (!rst) cur <= ST_STEP;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            ST_STEP: begin
                if (bus.halt_req)    nxt = ST_TRAP;
                else if (bus.run_sw) nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.halt_req)     nxt = ST_TRAP;
                else if (!bus.run_sw) nxt = ST_STEP;
            end
            ST_TRAP: begin
                if (bus.clr) nxt = ST_STEP;
            end
            default: nxt = ST_STEP;
        endcase
    end

    // Divider only advances while RUN is undisturbed; any other path clears it.
    always_comb begin
        strobe  = 1'b0;
        div_nxt = '0;
        case (cur)
            ST_STEP: begin
                if (!bus.halt_req && !bus.run_sw) strobe = step_evt;
            end
            ST_RUN: begin
                if (!bus.halt_req && bus.run_sw && !rate_chg) begin
                    if (div_cnt == div_last) strobe = 1'b1;
                    else                     div_nxt = div_cnt + DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_en_r   <= 1'b0;
            out_clk_r  <= 1'b0;
            inst_cnt_r <= '0;
            trap_r     <= 1'b0;
            div_cnt    <= '0;
        end else begin
            cpu_en_r <= strobe;
            div_cnt  <= div_nxt;
            trap_r   <= (nxt == ST_TRAP);
            if (strobe) begin
                inst_cnt_r <= inst_cnt_r + 32'd1;
                out_clk_r  <= ~out_clk_r;
            end
        end
    end

    assign bus.cpu_en   = cpu_en_r;
    assign bus.out_clk  = out_clk_r;
    assign bus.inst_cnt = inst_cnt_r;
    assign bus.trap     = trap_r;
    assign bus.state    = cur;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: a timestamp-based reference model queues
// expected outputs per edge, a negedge monitor compares them.
module tb_clk_step_ctrl;
    localparam int unsigned DSLOW = 10;
    localparam int unsigned DFAST = 4;
    localparam int unsigned DEB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clk_step_ctrl_if bus ();

    clk_step_ctrl #(.DIV_SLOW(DSLOW), .DIV_FAST(DFAST), .DEB_CYCLES(DEB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic        oc;
        logic [31:0] cnt;
        logic        tr;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button history indexed by edge number, strobe deadlines as timestamps.
    logic        btn_hist [0:16383];
    int          n = 0;
    int          reset_edge = 0;
    int          last_flip = -1;
    int          db_rise = -10;
    int          due = 0;
    logic        m_db = 1'b0;
    logic        rate_prev = 1'b0;
    logic [1:0]  m_st = 2'd0;
    logic        m_en = 1'b0;
    logic        m_oc = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    function automatic logic s2_at(input int j);
        if (j >= 2 && j - 2 > reset_edge) return btn_hist[j-2];
        return 1'b0;
    endfunction

    function automatic int divof(input logic r);
        return r ? int'(DFAST) : int'(DSLOW);
    endfunction

    always @(posedge clk) begin : model
        logic strobe;
        logic flip;
        logic evt;
        int   lo;
        n++;
        btn_hist[n] = bus.step_btn;
        strobe = 1'b0;
        if (!rst) begin
            m_st = 2'd0; m_en = 1'b0; m_oc = 1'b0; m_cnt = 32'd0; m_db = 1'b0;
            reset_edge = n; last_flip = -1; db_rise = -10;
        end else begin
            lo   = n - int'(DEB) + 1;
            flip = (lo > reset_edge) && (lo > last_flip);
            for (int j = lo; j <= n; j++) begin
                if (flip && s2_at(j) == m_db) flip = 1'b0;
            end
            evt = (db_rise == n - 1);
            if (flip) begin
                m_db = ~m_db;
                last_flip = n;
                if (m_db) db_rise = n;
            end
            case (m_st)
                2'd0: begin
                    if (bus.halt_req) m_st = 2'd2;
                    else if (bus.run_sw) begin
                        m_st = 2'd1;
                        due = n + divof(bus.rate_sel);
                    end else strobe = evt;
                end
                2'd1: begin
                    if (bus.halt_req) m_st = 2'd2;
                    else if (!bus.run_sw) m_st = 2'd0;
                    else if (bus.rate_sel != rate_prev) due = n + divof(bus.rate_sel);
                    else if (n == due) begin
                        strobe = 1'b1;
                        due = n + divof(bus.rate_sel);
                    end
                end
                default: begin
                    if (bus.clr) m_st = 2'd0;
                end
            endcase
            m_en = strobe;
            if (strobe) begin
                m_cnt = m_cnt + 32'd1;
                m_oc  = ~m_oc;
            end
        end
        rate_prev = bus.rate_sel;
        sb.push_back('{st: m_st, en: m_en, oc: m_oc, cnt: m_cnt, tr: (m_st == 2'd2)});
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state",    32'(bus.state),  32'(e.st));
            check("cpu_en",   32'(bus.cpu_en), 32'(e.en));
            check("out_clk",  32'(bus.out_clk), 32'(e.oc));
            check("inst_cnt", bus.inst_cnt,    e.cnt);
            check("trap",     32'(bus.trap),   32'(e.tr));
        end
    end

    initial begin : driver
        int   pulses;
        int   first;
        logic found;
        logic [31:0] cnt_before;
        bus.run_sw = 1'b0; bus.rate_sel = 1'b1; bus.step_btn = 1'b0;
        bus.halt_req = 1'b0; bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Step press held: strobe exactly after edge k+2+DEB
        bus.step_btn = 1'b1;
        pulses = 0; first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.cpu_en) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("step_pulses", 32'(pulses), 32'd1);
        check("step_latency", 32'(first), 32'd7);
        check("step_inst_cnt", bus.inst_cnt, 32'd1);
        check("step_out_clk", 32'(bus.out_clk), 32'd1);
        bus.step_btn = 1'b0;
        repeat (12) @(negedge clk);

        // Bounce shorter than the debounce window
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            repeat (2) begin
                @(negedge clk);
                if (bus.cpu_en) pulses++;
            end
            bus.step_btn = ~bus.step_btn;
        end
        bus.step_btn = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.cpu_en) pulses++;
        end
        check("bounce_pulses", 32'(pulses), 32'd0);
        check("bounce_inst_cnt", bus.inst_cnt, 32'd1);

        // RUN at the fast rate
        bus.run_sw = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (bus.cpu_en) pulses++;
        end
        check("run_fast_pulses", 32'(pulses), 32'd3);
        check("run_fast_inst_cnt", bus.inst_cnt, 32'd4);

        // Rate switch mid-count restarts the slow divider
        repeat (2) @(negedge clk);
        bus.rate_sel = 1'b0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.cpu_en && first == 0) first = i;
        end
        check("rate_switch_latency", 32'(first), 32'd11);

        // Halt coinciding with a due strobe
        bus.rate_sel = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.cpu_en) found = 1'b1;
        end
        check("halt_sync_pulse_seen", 32'(found), 32'd1);
        repeat (3) @(negedge clk);
        bus.halt_req = 1'b1;
        @(negedge clk);
        bus.halt_req = 1'b0;
        check("halt_no_strobe", 32'(bus.cpu_en), 32'd0);
        check("halt_state", 32'(bus.state), 32'd2);
        check("halt_trap", 32'(bus.trap), 32'd1);
        cnt_before = bus.inst_cnt;
        bus.step_btn = 1'b1;
        repeat (10) @(negedge clk);
        bus.step_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("trap_ignores_step", bus.inst_cnt, cnt_before);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_state", 32'(bus.state), 32'd0);
        check("clr_trap", 32'(bus.trap), 32'd0);

        // Reset mid-RUN
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("rst_out_clk", 32'(bus.out_clk), 32'd0);
        check("rst_inst_cnt", bus.inst_cnt, 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) bus.run_sw   = ~bus.run_sw;
            if ($urandom_range(0, 29) == 0) bus.rate_sel = ~bus.rate_sel;
            if ($urandom_range(0, 7)  == 0) bus.step_btn = ~bus.step_btn;
            bus.halt_req = ($urandom_range(0, 59) == 0);
            bus.clr      = ($urandom_range(0, 5) == 0);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Execution-rate controller for the single-cycle processor. It decides when the CPU may advance by issuing one-cycle `cpu_en` strobes from the board clock. There are three sources of advance: free-running at one of two divided rates, single-stepping from a debounced push button, or nothing at all while trapped. It replaces free-running divided clocks: the whole CPU stays on `clk` and qualifies its state updates with `cpu_en`.

## Interface
- `DIV_SLOW`, default 50000000: RUN-mode strobe period in `clk` cycles when `rate_sel`=0; must be ≥2.
- `DIV_FAST`, default 50000: RUN-mode strobe period when `rate_sel`=1; must be ≥2.
- `DEB_CYCLES`, default 1000000: consecutive stable cycles required to accept a new button level; must be ≥1.
- `clk` input 1: board clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `run_sw` input 1: level; 1 = RUN, 0 = STEP.
- `rate_sel` input 1: level; 0 = `DIV_SLOW`, 1 = `DIV_FAST`.
- `step_btn` input 1: raw asynchronous push button, active-high.
- `halt_req` input 1: from CPU halt-instruction decode; sampled every cycle.
- `clr` input 1: synchronous trap clear.
- `cpu_en` output 1: one-cycle advance strobe, registered.
- `out_clk` output 1: toggles on every `cpu_en`; drives an LED.
- `state` output 2: 0 = STEP, 1 = RUN, 2 = TRAP.
- `inst_cnt` output 32: number of `cpu_en` strobes issued; wraps modulo 2^32.
- `trap` output 1: high while in TRAP.

## Operation
- Reset (`rst`=0 at an edge): `state`=STEP, `cpu_en`=0, `out_clk`=0, `inst_cnt`=0, `trap`=0, divider count=0, sync FFs=0, debounced level=0, debounce count=0.
- Button path:
  - Two-FF synchronizer produces `s2`.
  - If `s2` equals the debounced level `db`, the debounce count clears.
  - Otherwise the count increments. When it equals `DEB_CYCLES`-1 while `s2`≠`db`, `db` takes `s2` and the count clears.
  - A step event is a 0→1 transition of `db`. The button path runs in every state, but events count only in STEP.
- STEP: a step event makes `cpu_en`=1 on the next cycle. `run_sw`=1 moves to RUN, with the divider count cleared to 0.
- RUN:
  - The divider count runs 0..DIV-1. At DIV-1 it wraps to 0 and `cpu_en`=1 on the next cycle.
  - `run_sw`=0 moves to STEP with the count cleared. A strobe due in that same cycle is dropped.
  - A change of `rate_sel` (a one-cycle registered copy is compared) clears the count, and no strobe is issued that cycle.
- TRAP: `cpu_en` is held at 0 and step events are ignored. `clr`=1 moves to STEP and clears `trap`.
- Transition priority, per cycle:
  1. `halt_req`=1 while in STEP or RUN moves to TRAP, and any strobe due that cycle is suppressed.
  2. Otherwise the `run_sw` transition applies.
  3. Otherwise normal counting or stepping proceeds.
- `halt_req` and `clr` both high in TRAP: the machine goes to STEP. The next cycle's `halt_req` may then re-trap it.
- `inst_cnt` increments and `out_clk` inverts in the same cycle that `cpu_en`=1.
- Reset asserted mid-RUN or mid-debounce discards all progress. The first edge with `rst`=1 behaves as the cycle after reset.

## Timing
- All outputs are registered; no combinational paths from input to output.
- RUN strobes:
  - Entering RUN at edge e clears the count at e.
  - The first `cpu_en` is high in the cycle after edge e+DIV, and strobes repeat every DIV cycles.
  - Each strobe lasts exactly 1 cycle.
- Step latency: let k be the first edge sampling `step_btn`=1, with the button held. Then `db` rises at edge k+1+`DEB_CYCLES` and `cpu_en` is high after edge k+2+`DEB_CYCLES`.
- Bounce: a button pulse shorter than `DEB_CYCLES` cycles after sync produces no event.
- State changes are visible on `state` in the cycle after the causing input is sampled.

## Test plan
- Reset, then `run_sw`=0 with `DEB_CYCLES`=4: hold `step_btn`=1 from edge k → `cpu_en` is high only after edge k+6, for exactly 1 cycle; `inst_cnt`=1, `out_clk`=1.
- Bounce: toggle `step_btn` every 2 cycles for 20 cycles, then hold it low → no `cpu_en`, `inst_cnt` unchanged.
- `DIV_FAST`=4, `rate_sel`=1, `run_sw`=1 entered at edge e → `cpu_en` pulses after edges e+4, e+8, e+12; `inst_cnt`=3 after 13 cycles.
- `DIV_SLOW`=10, `rate_sel` switched 1→0 mid-count → count restarts and the next strobe comes exactly 10 cycles after the switch edge; there is never a strobe in the switch cycle.
- `halt_req`=1 in the same cycle a RUN strobe is due → no `cpu_en`; `state`=2 and `trap`=1 next cycle; step presses are ignored; `clr`=1 → `state`=0.
- Hold `rst`=0 for one edge mid-RUN with `inst_cnt`=5 → all outputs return to reset values on that edge and `state`=STEP.
